fifo_wr_arbiter: RTL and testbench

//  - Round-robin, packet-locked arbiter sharing the write port of one sync_fifo among NUM_REQ sources.
//  - Each source presents valid/ready/last words; the arbiter drives fifo_wr_en/fifo_din.
//  - The grant is held until the source's last word, so packets never interleave inside the FIFO.
//  - fifo_prog_full gates new packet starts; fifo_full stalls words mid-packet.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one sync_fifo write port among NUM_REQ sources.
// Latency: 1 arbitration bubble per packet, then zero-latency combinational pass-through of words to the FIFO.
// Backpressure: fifo_prog_full blocks new packet starts; fifo_full stalls the granted source mid-packet.
//
// Ports: clk/resetn (sync, active-low); req_valid/req_data/req_last/req_ready per source;
//        fifo_wr_en/fifo_din/fifo_full/fifo_prog_full to the FIFO; grant_idx/busy status.
// Optional feature: define FIFO_ARB_TAG_EN to prepend the source index to fifo_din.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
  localparam int FIFO_DIN_W = DATA_WIDTH + 1 + IDX_W
`else
  localparam int FIFO_DIN_W = DATA_WIDTH + 1
`endif
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_DIN_W-1:0]         fifo_din,
  input  logic                          fifo_full,
  input  logic                          fifo_prog_full,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  // Round-robin pick: first valid source strictly after last_grant, wrapping.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Currently granted source's word.
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;

  assign g_valid = req_valid[grant_idx_q];
  assign g_last  = req_last[grant_idx_q];
  assign g_data  = req_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign xfer    = (state_q == LOCKED) & g_valid & ~fifo_full;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && !fifo_prog_full) begin
          state_d     = LOCKED;
          grant_idx_d = pick_idx;
        end
      end
      LOCKED: begin
        // prog_full is deliberately ignored here: a started packet always completes.
        if (xfer && g_last) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Handshakes are masked while resetn is low so the word
  // presented during the reset cycle is not consumed by an abandoned packet.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    if (state_q == LOCKED && resetn) begin
      req_ready[grant_idx_q] = ~fifo_full;
      fifo_wr_en             = g_valid & ~fifo_full;
    end
  end

`ifdef FIFO_ARB_TAG_EN
  assign fifo_din = {grant_idx_q, g_last, g_data};
`else
  assign fifo_din = {g_last, g_data};
`endif

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: source models feed words, a monitor checks every FIFO write.
// Expected writes are queued by the stimulus in hand-derived arbitration order.
// Directed checks cover reset, gaps, full stalls, prog_full gating and mid-packet reset.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
`ifdef FIFO_ARB_TAG_EN
  localparam int DIN_W = DW + 1 + 2;
`else
  localparam int DIN_W = DW + 1;
`endif

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      req_ready;
  logic               fifo_wr_en;
  logic [DIN_W-1:0]   fifo_din;
  logic               fifo_full = 1'b0;
  logic               fifo_prog_full = 1'b0;
  logic [1:0]         grant_idx;
  logic               busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source models: per-source word storage, write pointer from stimulus, read pointer on handshake.
  logic [DW:0] mem [NR][16];
  int          wp  [NR];
  int          rp  [NR];
  logic [NR-1:0] gap = '0;

  initial for (int i = 0; i < NR; i++) wp[i] = 0;

  always @(posedge clk) begin
    if (!resetn && rp[0] === 'x) begin
      for (int i = 0; i < NR; i++) rp[i] <= 0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) rp[i] <= rp[i] + 1;
    end
  end

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (rp[i] != wp[i]) && !gap[i];
      req_data[i*DW +: DW]  = mem[i][rp[i] % 16][DW-1:0];
      req_last[i]           = mem[i][rp[i] % 16][DW];
    end
  end

  // Scoreboard
  logic [DIN_W-1:0] exp_din_q [$];
  logic [1:0]       exp_src_q [$];
  int               wr_count = 0;
  int               wr_cyc [64];
  int               cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DIN_W-1:0] mk_din(input int s, input logic l, input logic [DW-1:0] d);
    logic [1:0] t;
    t = s[1:0];
`ifdef FIFO_ARB_TAG_EN
    return {t, l, d};
`else
    if (t == 2'b00) return {l, d};
    return {l, d};
`endif
  endfunction

  task automatic push_exp(input int s, input logic [DIN_W-1:0] din);
    logic [1:0] t;
    t = s[1:0];
    exp_din_q.push_back(din);
    exp_src_q.push_back(t);
  endtask

  task automatic load_word(input int s, input logic [DW-1:0] d, input logic l, input bit expect_it);
    mem[s][wp[s] % 16] = {l, d};
    wp[s] = wp[s] + 1;
    if (expect_it) push_exp(s, mk_din(s, l, d));
  endtask

  // Monitor: checks invariants every cycle and pops the scoreboard on every write.
  initial forever begin
    logic [DIN_W-1:0] ed;
    logic [1:0]       es;
    @(negedge clk);
    cyc++;
    check("ready_onehot", {63'd0, ($countones(req_ready) <= 1)}, 64'd1);
    check("no_write_while_full", {63'd0, fifo_wr_en & fifo_full}, 64'd0);
    if (fifo_wr_en === 1'b1) begin
      if (wr_count < 64) wr_cyc[wr_count] = cyc;
      wr_count++;
      if (exp_din_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got din %0h, expected no write", fifo_din);
      end else begin
        ed = exp_din_q.pop_front();
        es = exp_src_q.pop_front();
        check("write_din", 64'(fifo_din), 64'(ed));
        check("write_grant", 64'(grant_idx), 64'(es));
      end
    end
  end

  task automatic wait_writes(input int target, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (wr_count < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wr_count, target);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [DIN_W-1:0] din6;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    next_drive();
    resetn = 1'b1;

    // 1: all four sources, 2-word packets -> grants 0,1,2,3 with one bubble between packets
    next_drive();
    for (int s = 0; s < NR; s++) begin
      load_word(s, 32'h1000_0000 + 32'(s * 16), 1'b0, 1'b1);
      load_word(s, 32'h1000_0001 + 32'(s * 16), 1'b1, 1'b1);
    end
    wait_writes(8, "t1");
    check("t1_span", 64'(wr_cyc[7] - wr_cyc[0]), 64'd10);
    check("t1_bubble", 64'(wr_cyc[2] - wr_cyc[1]), 64'd2);
    check("t1_queue_empty", 64'(exp_din_q.size()), 64'd0);

    // 2: source 2, 4 words, valid gap of 3 cycles after word 1; source 0 waits
    next_drive();
    for (int w = 0; w < 4; w++) load_word(2, 32'h2000_0000 + 32'(w), (w == 3), 1'b1);
    base = wr_count;
    wait_writes(base + 1, "t2_first");
    next_drive();
    gap[2] = 1'b1;
    load_word(0, 32'h2000_00F0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_grant_held", 64'(grant_idx), 64'd2);
      check("t2_busy", 64'(busy), 64'd1);
      check("t2_src0_not_ready", 64'(req_ready[0]), 64'd0);
      check("t2_no_write", 64'(fifo_wr_en), 64'd0);
    end
    next_drive();
    gap[2] = 1'b0;
    wait_writes(base + 5, "t2");
    check("t2_queue_empty", 64'(exp_din_q.size()), 64'd0);

    // 3: fifo_full for 5 cycles mid-packet from source 1
    next_drive();
    for (int w = 0; w < 3; w++) load_word(1, 32'h3000_0000 + 32'(w), (w == 2), 1'b1);
    base = wr_count;
    wait_writes(base + 1, "t3_first");
    next_drive();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_full_no_write", 64'(fifo_wr_en), 64'd0);
      check("t3_full_no_ready", 64'(req_ready), 64'd0);
    end
    next_drive();
    fifo_full = 1'b0;
    @(negedge clk);
    check("t3_write_on_release", 64'(fifo_wr_en), 64'd1);
    wait_writes(base + 3, "t3");
    check("t3_queue_empty", 64'(exp_din_q.size()), 64'd0);

    // 4: prog_full holds IDLE; lock on source 1 the cycle after it clears
    next_drive();
    fifo_prog_full = 1'b1;
    load_word(1, 32'h4000_0000, 1'b0, 1'b1);
    load_word(1, 32'h4000_0001, 1'b1, 1'b1);
    base = wr_count;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_idle_busy", 64'(busy), 64'd0);
      check("t4_idle_ready", 64'(req_ready), 64'd0);
    end
    next_drive();
    fifo_prog_full = 1'b0;
    @(negedge clk);
    check("t4_still_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("t4_locked", 64'(busy), 64'd1);
    check("t4_grant", 64'(grant_idx), 64'd1);
    next_drive();
    fifo_prog_full = 1'b1;   // ignored mid-packet
    wait_writes(base + 2, "t4");
    next_drive();
    fifo_prog_full = 1'b0;
    check("t4_queue_empty", 64'(exp_din_q.size()), 64'd0);

    // 5: reset during word 2 of a packet from source 3
    next_drive();
    load_word(3, 32'h5000_0000, 1'b0, 1'b1);
    load_word(3, 32'h5000_0001, 1'b0, 1'b0);
    load_word(3, 32'h5000_0002, 1'b1, 1'b0);
    base = wr_count;
    wait_writes(base + 1, "t5_first");
    next_drive();
    resetn = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    check("t5_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    next_drive();
    resetn = 1'b1;
    load_word(0, 32'h5000_00A0, 1'b1, 1'b1);
    push_exp(3, mk_din(3, 1'b0, 32'h5000_0001));
    push_exp(3, mk_din(3, 1'b1, 32'h5000_0002));
    @(negedge clk);
    check("t5_idle_busy", 64'(busy), 64'd0);
    check("t5_idle_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t5_grant_src0", 64'(grant_idx), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
    wait_writes(base + 4, "t5");
    check("t5_queue_empty", 64'(exp_din_q.size()), 64'd0);

    // 6: source 1 single word A5A5_0001 with last
    next_drive();
`ifdef FIFO_ARB_TAG_EN
    din6 = {2'b01, 1'b1, 32'hA5A5_0001};
`else
    din6 = {1'b1, 32'hA5A5_0001};
`endif
    load_word(1, 32'hA5A5_0001, 1'b1, 1'b0);
    push_exp(1, din6);
    base = wr_count;
    wait_writes(base + 1, "t6");
    check("t6_queue_empty", 64'(exp_din_q.size()), 64'd0);
    check("total_writes", 64'(wr_count), 64'd23);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
